// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver, 5-8 data bits LSB first, optional parity, pe/fe/bi flags
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling over the last three 16x ticks
module uart_rx (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       uart_rx_en_i,
  input  logic       bclk_tick_i,
  input  logic [1:0] lcr_wlen_i,
  input  logic       lcr_pen_i,
  input  logic       lcr_eps_i,
  input  logic       lcr_sps_i,
  input  logic       uart_rx_i,
  output logic [7:0] uart_rx_data_o,
  output logic       uart_rx_data_vld_o,
  output logic       uart_rx_pe_o,
  output logic       uart_rx_fe_o,
  output logic       uart_rx_bi_o,
  output logic       uart_rx_busy_o
);
  typedef enum logic [2:0] {
    S_RX_IDLE,
    S_RX_START,
    S_RX_DATA,
    S_RX_PAR,
    S_RX_STOP,
    S_RX_WAIT
  } state_e;
  state_e     state_q, state_d;
  logic [1:0] sync_q, sync_d;
  logic [3:0] tick_cnt_q, tick_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] data_q, data_d;
  logic       par_q, par_d;
  logic       vld_q, vld_d;
  logic       pe_q, pe_d;
  logic       fe_q, fe_d;
  logic       bi_q, bi_d;
  logic       line, s, samp, exp_par, last_bit;
  logic [7:0] rx_data;
  assign sync_d = {sync_q[0], uart_rx_i};
  assign line   = sync_q[1];
`ifdef UART_RX_MAJORITY_EN
  logic [2:0] hist_q, hist_d;
  assign hist_d = bclk_tick_i ? {hist_q[1:0], line} : hist_q;
  assign s      = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
`else
  logic hist_q, hist_d;
  assign hist_d = bclk_tick_i ? line : hist_q;
  assign s      = hist_q;
`endif
  assign samp     = bclk_tick_i && tick_cnt_q == 4'd15;
  assign last_bit = bit_cnt_q == 3'd4 + {1'b0, lcr_wlen_i};
  assign rx_data  = shreg_q >> (2'd3 - lcr_wlen_i);
  assign exp_par  = lcr_sps_i ? ~lcr_eps_i : lcr_eps_i ^ (^rx_data);
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = (bclk_tick_i && state_q != S_RX_IDLE) ? tick_cnt_q + 4'd1 : tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    vld_d      = 1'b0;
    data_d     = 8'h00;
    pe_d       = 1'b0;
    fe_d       = 1'b0;
    bi_d       = 1'b0;
    case (state_q)
      S_RX_IDLE: begin
        if (bclk_tick_i && !line) begin
          state_d    = S_RX_START;
          tick_cnt_d = 4'd0;
        end
      end
      S_RX_START: begin
        if (bclk_tick_i && tick_cnt_q == 4'd7) begin
          state_d    = s ? S_RX_IDLE : S_RX_DATA;
          tick_cnt_d = 4'd0;
          bit_cnt_d  = 3'd0;
        end
      end
      S_RX_DATA: begin
        if (samp) begin
          shreg_d   = {s, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          state_d   = !last_bit ? S_RX_DATA : lcr_pen_i ? S_RX_PAR : S_RX_STOP;
        end
      end
      S_RX_PAR: begin
        if (samp) begin
          par_d   = s;
          state_d = S_RX_STOP;
        end
      end
      S_RX_STOP: begin
        if (samp) begin
          vld_d   = 1'b1;
          data_d  = rx_data;
          pe_d    = lcr_pen_i & (par_q != exp_par);
          fe_d    = !s;
          bi_d    = rx_data == 8'h00 && (!lcr_pen_i || !par_q) && !s;
          state_d = s ? S_RX_IDLE : S_RX_WAIT;
        end
      end
      S_RX_WAIT: state_d = (bclk_tick_i && line) ? S_RX_IDLE : S_RX_WAIT;
      default:   state_d = S_RX_IDLE;
    endcase
    if (!uart_rx_en_i) begin
      state_d    = S_RX_IDLE;
      tick_cnt_d = 4'd0;
      bit_cnt_d  = 3'd0;
      vld_d      = 1'b0;
      data_d     = 8'h00;
      pe_d       = 1'b0;
      fe_d       = 1'b0;
      bi_d       = 1'b0;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_RX_IDLE;
      sync_q     <= 2'b11;
      hist_q     <= '1;
      tick_cnt_q <= 4'd0;
      bit_cnt_q  <= 3'd0;
      shreg_q    <= 8'h00;
      par_q      <= 1'b0;
      vld_q      <= 1'b0;
      data_q     <= 8'h00;
      pe_q       <= 1'b0;
      fe_q       <= 1'b0;
      bi_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      hist_q     <= hist_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      vld_q      <= vld_d;
      data_q     <= data_d;
      pe_q       <= pe_d;
      fe_q       <= fe_d;
      bi_q       <= bi_d;
    end
  end
  assign uart_rx_data_o     = data_q;
  assign uart_rx_data_vld_o = vld_q;
  assign uart_rx_pe_o       = pe_q;
  assign uart_rx_fe_o       = fe_q;
  assign uart_rx_bi_o       = bi_q;
  assign uart_rx_busy_o     = state_q != S_RX_IDLE;
endmodule
